video_capture_writer: RTL and testbench

VIDEO_CAPTURE_WRITER -- requirements
Module: video_capture_writer

---
 rtl/video_capture_pkg.sv | 33 +++
 rtl/video_capture_writer_if.sv | 25 ++
 rtl/pixel_word_packer.sv | 61 ++++++
 rtl/video_capture_writer.sv | 172 +++++++++++++++++
 tb/tb_video_capture_writer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_capture_pkg.sv
// Shared definitions for the video capture writer.
// Contents: FSM state enum, pixel/word geometry, memory address width,
// and a helper that builds byte enables for a partially filled word.
package video_capture_pkg;

  localparam int unsigned PIXEL_BYTES     = 4;
  localparam int unsigned PIXELS_PER_WORD = 8;
  localparam int unsigned ADDR_W          = 13;
  localparam int unsigned PIX_W           = PIXEL_BYTES * 8;
  localparam int unsigned WORD_W          = PIX_W * PIXELS_PER_WORD;
  localparam int unsigned BE_W            = PIXEL_BYTES * PIXELS_PER_WORD;
  localparam int unsigned CNT_W           = 14;
  localparam int unsigned STAT_W          = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_CAPTURE,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // Byte enables covering the lowest n pixels of a word.
  function automatic logic [BE_W-1:0] pixel_byte_mask(input logic [2:0] n);
    logic [BE_W-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < PIXELS_PER_WORD; k++) begin
      if (k < 32'(n)) m[k*PIXEL_BYTES +: PIXEL_BYTES] = '1;
    end
    return m;
  endfunction

endpackage

// File: rtl/video_capture_writer_if.sv
// On-chip memory write port of the video capture writer.
// Signals: chip_select, clken, write strobe, 13-bit word address,
// 256-bit write data, 32-bit byte enables.
// Modports: master (capture writer drives), slave (memory receives).
interface video_capture_writer_if;
  import video_capture_pkg::*;

  logic              onchip_mem_chip_select;
  logic              onchip_mem_clken;
  logic              onchip_mem_write;
  logic [ADDR_W-1:0] onchip_mem_addr;
  logic [WORD_W-1:0] onchip_mem_write_data;
  logic [BE_W-1:0]   onchip_mem_byte_enable;

  modport master (
    output onchip_mem_chip_select, onchip_mem_clken, onchip_mem_write,
           onchip_mem_addr, onchip_mem_write_data, onchip_mem_byte_enable
  );

  modport slave (
    input onchip_mem_chip_select, onchip_mem_clken, onchip_mem_write,
          onchip_mem_addr, onchip_mem_write_data, onchip_mem_byte_enable
  );

endinterface

// File: rtl/pixel_word_packer.sv
// Packs 32-bit pixels into 256-bit words, pixel k at bits [32k+31:32k].
// Ports:
//   clk_100m, reset_n  clock / synchronous active-low reset
//   clear              drop any partially packed word
//   pix_valid/pix_data one pixel to append
//   flush              emit the partial word (no output if nothing pending)
//   word_valid         one-cycle pulse, the cycle after the word completes
//   word_data/word_be  packed word and its byte enables
module pixel_word_packer
  import video_capture_pkg::*;
(
  input  logic              clk_100m,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              flush,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data,
  output logic [BE_W-1:0]   word_be
);

  logic [2:0]        cnt_q;
  logic [WORD_W-1:0] acc_q;

  always_ff @(posedge clk_100m) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_be    <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        cnt_q <= '0;
        acc_q <= '0;
      end else if (pix_valid) begin
        if (cnt_q == 3'd7) begin
          // Eighth pixel goes straight to the output register.
          word_valid <= 1'b1;
          word_data  <= {pix_data, acc_q[WORD_W-PIX_W-1:0]};
          word_be    <= '1;
          cnt_q      <= '0;
          acc_q      <= '0;
        end else begin
          acc_q[{cnt_q, 5'b0} +: PIX_W] <= pix_data;
          cnt_q                         <= cnt_q + 3'd1;
        end
      end else if (flush && cnt_q != 3'd0) begin
        // Unfilled slots were zeroed when the previous word left.
        word_valid <= 1'b1;
        word_data  <= acc_q;
        word_be    <= pixel_byte_mask(cnt_q);
        cnt_q      <= '0;
        acc_q      <= '0;
      end
    end
  end

endmodule

// File: rtl/video_capture_writer.sv
// Captures one video frame into on-chip memory as packed 256-bit words.
// Ports:
//   clk_100m, reset_n            clock / synchronous active-low reset
//   capture_start, capture_abort single-cycle control requests
//   vid_de/hs/vs, vid_r/g/b      video input (vid_hs is not used)
//   mem                          memory write port (master)
//   busy, capture_done, overflow status
//   word_count                   words written this capture
//   line_count, pixels_per_line  frame statistics
// Build option: define VIDEO_CAPTURE_STATS_EN to enable the statistics;
// otherwise line_count and pixels_per_line read 0.
module video_capture_writer
  import video_capture_pkg::*;
#(
  parameter int unsigned MEM_WORDS      = 8192,
  parameter bit          VS_ACTIVE_HIGH = 1'b1
) (
  input  logic                  clk_100m,
  input  logic                  reset_n,
  input  logic                  capture_start,
  input  logic                  capture_abort,
  input  logic                  vid_de,
  input  logic                  vid_hs,
  input  logic                  vid_vs,
  input  logic [7:0]            vid_r,
  input  logic [7:0]            vid_g,
  input  logic [7:0]            vid_b,
  video_capture_writer_if.master mem,
  output logic                  busy,
  output logic                  capture_done,
  output logic                  overflow,
  output logic [CNT_W-1:0]      word_count,
  output logic [STAT_W-1:0]     line_count,
  output logic [STAT_W-1:0]     pixels_per_line
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);
  localparam logic [CNT_W-1:0]  WC_MAX    = CNT_W'(MEM_WORDS);

  state_t state_q, state_d;
  logic   vs_act, vs_q, vs_edge;
  logic   abort_hit, arm_exit, pix_valid, flush, clear;
  logic   word_valid, wr_fire, wr_drop;
  logic [WORD_W-1:0] word_data;
  logic [BE_W-1:0]   word_be;
  logic [ADDR_W-1:0] addr_q;
  logic              full_q;

  logic unused_hs;
  assign unused_hs = vid_hs;

  assign vs_act  = VS_ACTIVE_HIGH ? vid_vs : ~vid_vs;
  assign vs_edge = vs_act & ~vs_q;

  always_ff @(posedge clk_100m) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (capture_start) state_d = ST_ARM;
      ST_ARM:     if (capture_abort) state_d = ST_IDLE;
                  else if (vs_edge)  state_d = ST_CAPTURE;
      ST_CAPTURE: if (capture_abort) state_d = ST_IDLE;
                  else if (vs_edge)  state_d = ST_FLUSH;
      ST_FLUSH:   if (capture_abort) state_d = ST_IDLE;
                  else               state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != ST_IDLE);
    capture_done = (state_q == ST_DONE);
    abort_hit    = capture_abort && (state_q inside {ST_ARM, ST_CAPTURE, ST_FLUSH});
    arm_exit     = (state_q == ST_ARM) && vs_edge && !capture_abort;
    // A vsync edge wins over a coincident pixel: that pixel is dropped.
    pix_valid    = (state_q == ST_CAPTURE) && vid_de && !vs_edge && !capture_abort;
    flush        = (state_q == ST_CAPTURE) && vs_edge && !capture_abort;
    clear        = arm_exit || abort_hit;
  end

  pixel_word_packer u_packer (
    .clk_100m   (clk_100m),
    .reset_n    (reset_n),
    .clear      (clear),
    .pix_valid  (pix_valid),
    .pix_data   ({8'h00, vid_r, vid_g, vid_b}),
    .flush      (flush),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_be    (word_be)
  );

  // The packer output is registered, so an abort arriving while a word is
  // presented (e.g. the flush word in FLUSH) must veto it combinationally.
  assign wr_fire = word_valid && !abort_hit && !full_q;
  assign wr_drop = word_valid && !abort_hit && full_q;

  always_ff @(posedge clk_100m) begin
    if (!reset_n) begin
      vs_q       <= 1'b0;
      addr_q     <= '0;
      full_q     <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      vs_q <= vs_act;
      if (state_q == ST_IDLE && capture_start) overflow <= 1'b0;
      if (arm_exit) begin
        addr_q     <= '0;
        full_q     <= 1'b0;
        word_count <= '0;
      end else begin
        if (wr_drop) overflow <= 1'b1;
        if (wr_fire) begin
          if (word_count != WC_MAX) word_count <= word_count + 1'b1;
          // The last address is used once; later words are suppressed.
          if (addr_q == LAST_ADDR) full_q <= 1'b1;
          else                     addr_q <= addr_q + 1'b1;
        end
      end
    end
  end

  assign mem.onchip_mem_chip_select = busy;
  assign mem.onchip_mem_clken       = busy;
  assign mem.onchip_mem_write       = wr_fire;
  assign mem.onchip_mem_addr        = addr_q;
  assign mem.onchip_mem_write_data  = word_data;
  assign mem.onchip_mem_byte_enable = word_be;

`ifdef VIDEO_CAPTURE_STATS_EN
  logic              de_q;
  logic [STAT_W-1:0] lines_q, ppl_q, run_q;

  always_ff @(posedge clk_100m) begin
    if (!reset_n) begin
      de_q    <= 1'b0;
      lines_q <= '0;
      ppl_q   <= '0;
      run_q   <= '0;
    end else begin
      de_q <= vid_de;
      if (arm_exit) begin
        lines_q <= '0;
        ppl_q   <= '0;
        run_q   <= '0;
      end else if (state_q == ST_CAPTURE && !vs_edge) begin
        if (vid_de && !de_q) begin
          lines_q <= lines_q + 1'b1;
          run_q   <= 12'd1;
        end else if (vid_de) begin
          run_q <= run_q + 1'b1;
        end else if (de_q) begin
          ppl_q <= run_q;
        end
      end
    end
  end

  assign line_count      = lines_q;
  assign pixels_per_line = ppl_q;
`else
  assign line_count      = '0;
  assign pixels_per_line = '0;
`endif

endmodule

// File: tb/tb_video_capture_writer.sv
module tb_video_capture_writer;
  import video_capture_pkg::*;

  logic clk_100m = 1'b0;
  always #5 clk_100m = ~clk_100m;

  logic       reset_n, capture_start, capture_abort, vid_de, vid_hs, vid_vs;
  logic [7:0] vid_r, vid_g, vid_b;

  logic        busy, capture_done, overflow;
  logic [13:0] word_count;
  logic [11:0] line_count, pixels_per_line;
  logic        busy_s, capture_done_s, overflow_s;
  logic [13:0] word_count_s;
  logic [11:0] line_count_s, pixels_per_line_s;

  video_capture_writer_if mif ();
  video_capture_writer_if mif_s ();

  video_capture_writer dut (
    .clk_100m(clk_100m), .reset_n(reset_n),
    .capture_start(capture_start), .capture_abort(capture_abort),
    .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
    .mem(mif),
    .busy(busy), .capture_done(capture_done), .overflow(overflow),
    .word_count(word_count), .line_count(line_count),
    .pixels_per_line(pixels_per_line)
  );

  video_capture_writer #(.MEM_WORDS(4)) dut_s (
    .clk_100m(clk_100m), .reset_n(reset_n),
    .capture_start(capture_start), .capture_abort(capture_abort),
    .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
    .mem(mif_s),
    .busy(busy_s), .capture_done(capture_done_s), .overflow(overflow_s),
    .word_count(word_count_s), .line_count(line_count_s),
    .pixels_per_line(pixels_per_line_s)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [12:0]  wr_addr [64];
  logic [31:0]  wr_be   [64];
  logic [255:0] wr_data [64];
  int n_wr = 0, n_done = 0, n_wr_s = 0, n_done_s = 0;
  logic [12:0] last_addr_s = '0;
  logic [31:0] last_be_s = '0;

  always @(negedge clk_100m) begin
    if (mif.onchip_mem_write && n_wr < 64) begin
      wr_addr[n_wr] = mif.onchip_mem_addr;
      wr_be[n_wr]   = mif.onchip_mem_byte_enable;
      wr_data[n_wr] = mif.onchip_mem_write_data;
      n_wr++;
    end
    if (capture_done) n_done++;
    if (mif_s.onchip_mem_write) begin
      last_addr_s = mif_s.onchip_mem_addr;
      last_be_s   = mif_s.onchip_mem_byte_enable;
      n_wr_s++;
    end
    if (capture_done_s) n_done_s++;
  end

  function automatic logic [31:0] exp_pix(input int p);
    logic [7:0] v;
    v = p[7:0];
    return {8'h00, v, ~v, 8'h5A};
  endfunction

  task automatic tick;
    @(posedge clk_100m);
    #1;
  endtask

  task automatic idle(input int n);
    vid_de = 1'b0;
    vid_hs = 1'b1;
    repeat (n) tick;
  endtask

  task automatic drive_pix(input int p);
    logic [7:0] v;
    v = p[7:0];
    vid_de = 1'b1;
    vid_hs = 1'b0;
    vid_r  = v;
    vid_g  = ~v;
    vid_b  = 8'h5A;
  endtask

  task automatic start_pulse;
    capture_start = 1'b1;
    tick;
    capture_start = 1'b0;
    tick;
  endtask

  task automatic vs_pulse;
    vid_vs = 1'b1;
    tick;
    vid_vs = 1'b0;
    tick;
  endtask

  task automatic run_frame(input int lines, input int ppl);
    start_pulse;
    vs_pulse;
    for (int l = 0; l < lines; l++) begin
      for (int k = 0; k < ppl; k++) begin
        drive_pix(l * ppl + k);
        tick;
      end
      idle(2);
    end
    vs_pulse;
    idle(4);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    idle(3);
    n_cmp++;
    if ({busy, capture_done, overflow} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_status: got %b expected 000", {busy, capture_done, overflow});
    end
    n_cmp++;
    if ({word_count, line_count, pixels_per_line} !== 38'd0) begin
      n_bad++;
      $display("FAIL reset_counts: got wc=%0d lc=%0d ppl=%0d expected 0", word_count, line_count, pixels_per_line);
    end
    n_cmp++;
    if ({mif.onchip_mem_chip_select, mif.onchip_mem_clken, mif.onchip_mem_write} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_mem_ctrl: got %b expected 000",
               {mif.onchip_mem_chip_select, mif.onchip_mem_clken, mif.onchip_mem_write});
    end
    n_cmp++;
    if (mif.onchip_mem_addr !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_addr: got %0d expected 0", mif.onchip_mem_addr);
    end
    n_cmp++;
    if (mif.onchip_mem_write_data !== 256'd0 || mif.onchip_mem_byte_enable !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_data_be: got data %h be %h expected 0", mif.onchip_mem_write_data, mif.onchip_mem_byte_enable);
    end
    reset_n = 1'b1;
    idle(2);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_full_frame;
    int base, d0;
    logic [11:0] exp_lc, exp_ppl;
    base = n_wr;
    d0   = n_done;
    run_frame(4, 16);
    n_cmp++;
    if (n_wr - base !== 8) begin
      n_bad++;
      $display("FAIL frame_write_count: got %0d expected 8", n_wr - base);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (wr_addr[base+i] !== 13'(i) || wr_be[base+i] !== 32'hFFFF_FFFF) begin
        n_bad++;
        $display("FAIL frame_word%0d: got addr %0d be %h expected addr %0d be ffffffff", i, wr_addr[base+i], wr_be[base+i], i);
      end
    end
    n_cmp++;
    if (wr_data[base][31:0] !== exp_pix(0) || wr_data[base+7][255:224] !== exp_pix(63)) begin
      n_bad++;
      $display("FAIL frame_data: got %h/%h expected %h/%h",
               wr_data[base][31:0], wr_data[base+7][255:224], exp_pix(0), exp_pix(63));
    end
    n_cmp++;
    if (word_count !== 14'd8) begin
      n_bad++;
      $display("FAIL frame_word_count: got %0d expected 8", word_count);
    end
    n_cmp++;
    if (n_done - d0 !== 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_done: got done=%0d busy=%b expected done=1 busy=0", n_done - d0, busy);
    end
`ifdef VIDEO_CAPTURE_STATS_EN
    exp_lc  = 12'd4;
    exp_ppl = 12'd16;
`else
    exp_lc  = 12'd0;
    exp_ppl = 12'd0;
`endif
    n_cmp++;
    if (line_count !== exp_lc || pixels_per_line !== exp_ppl) begin
      n_bad++;
      $display("FAIL frame_stats: got lc=%0d ppl=%0d expected lc=%0d ppl=%0d", line_count, pixels_per_line, exp_lc, exp_ppl);
    end
  endtask

  task automatic test_partial_flush;
    int base, d0;
    logic exp_w;
    base = n_wr;
    d0   = n_done;
    start_pulse;
    vs_pulse;
    n_cmp++;
    if (mif.onchip_mem_chip_select !== 1'b1 || mif.onchip_mem_clken !== 1'b1) begin
      n_bad++;
      $display("FAIL partial_cs_clken: got %b%b expected 11", mif.onchip_mem_chip_select, mif.onchip_mem_clken);
    end
    for (int k = 0; k < 20; k++) begin
      drive_pix(k);
      tick;
      exp_w = ((k % 8) == 7);
      n_cmp++;
      if (mif.onchip_mem_write !== exp_w) begin
        n_bad++;
        $display("FAIL partial_write_timing_px%0d: got %b expected %b", k, mif.onchip_mem_write, exp_w);
      end
    end
    idle(2);
    vid_vs = 1'b1;
    tick;
    n_cmp++;
    if (mif.onchip_mem_write !== 1'b1 || mif.onchip_mem_byte_enable !== 32'h0000_FFFF) begin
      n_bad++;
      $display("FAIL partial_flush_cycle: got wr=%b be=%h expected wr=1 be=0000ffff",
               mif.onchip_mem_write, mif.onchip_mem_byte_enable);
    end
    vid_vs = 1'b0;
    tick;
    idle(4);
    n_cmp++;
    if (n_wr - base !== 3 || wr_addr[base+2] !== 13'd2 || wr_be[base+2] !== 32'h0000_FFFF) begin
      n_bad++;
      $display("FAIL partial_writes: got n=%0d addr=%0d be=%h expected n=3 addr=2 be=0000ffff",
               n_wr - base, wr_addr[base+2], wr_be[base+2]);
    end
    n_cmp++;
    if (wr_data[base+2] !== {128'd0, exp_pix(19), exp_pix(18), exp_pix(17), exp_pix(16)}) begin
      n_bad++;
      $display("FAIL partial_data: got %h", wr_data[base+2]);
    end
    n_cmp++;
    if (word_count !== 14'd3 || n_done - d0 !== 1) begin
      n_bad++;
      $display("FAIL partial_done: got wc=%0d done=%0d expected wc=3 done=1", word_count, n_done - d0);
    end
  endtask

  task automatic test_overflow;
    int base, base_s, ds0;
    logic [11:0] exp_lc, exp_ppl;
    base   = n_wr;
    base_s = n_wr_s;
    ds0    = n_done_s;
    run_frame(3, 16);
    n_cmp++;
    if (n_wr_s - base_s !== 4 || last_addr_s !== 13'd3 || last_be_s !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL ovf_writes: got n=%0d last_addr=%0d be=%h expected n=4 addr=3 be=ffffffff",
               n_wr_s - base_s, last_addr_s, last_be_s);
    end
    n_cmp++;
    if (overflow_s !== 1'b1 || mif_s.onchip_mem_addr !== 13'd3) begin
      n_bad++;
      $display("FAIL ovf_flag_addr: got ovf=%b addr=%0d expected ovf=1 addr=3", overflow_s, mif_s.onchip_mem_addr);
    end
    n_cmp++;
    if (word_count_s !== 14'd4 || n_done_s - ds0 !== 1 || busy_s !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_end: got wc=%0d done=%0d busy=%b expected wc=4 done=1 busy=0",
               word_count_s, n_done_s - ds0, busy_s);
    end
    n_cmp++;
    if (n_wr - base !== 6 || overflow !== 1'b0 || word_count !== 14'd6) begin
      n_bad++;
      $display("FAIL ovf_big_mem: got n=%0d ovf=%b wc=%0d expected n=6 ovf=0 wc=6", n_wr - base, overflow, word_count);
    end
`ifdef VIDEO_CAPTURE_STATS_EN
    exp_lc  = 12'd3;
    exp_ppl = 12'd16;
`else
    exp_lc  = 12'd0;
    exp_ppl = 12'd0;
`endif
    n_cmp++;
    if (line_count_s !== exp_lc || pixels_per_line_s !== exp_ppl) begin
      n_bad++;
      $display("FAIL ovf_stats: got lc=%0d ppl=%0d expected lc=%0d ppl=%0d", line_count_s, pixels_per_line_s, exp_lc, exp_ppl);
    end
  endtask

  task automatic test_abort;
    int base, d0;
    base = n_wr;
    d0   = n_done;
    start_pulse;
    n_cmp++;
    if (overflow_s !== 1'b0 || busy_s !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_arm_clears_ovf: got ovf=%b busy=%b expected ovf=0 busy=1", overflow_s, busy_s);
    end
    vs_pulse;
    for (int k = 0; k < 26; k++) begin
      drive_pix(k);
      tick;
    end
    idle(1);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_pre_busy: got %b expected 1", busy);
    end
    capture_abort = 1'b1;
    tick;
    capture_abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || mif.onchip_mem_chip_select !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle_next: got busy=%b cs=%b expected 0 0", busy, mif.onchip_mem_chip_select);
    end
    vs_pulse;
    idle(4);
    n_cmp++;
    if (n_wr - base !== 3 || n_done - d0 !== 0 || word_count !== 14'd3) begin
      n_bad++;
      $display("FAIL abort_result: got n=%0d done=%0d wc=%0d expected n=3 done=0 wc=3", n_wr - base, n_done - d0, word_count);
    end
  endtask

  task automatic test_reset_mid;
    start_pulse;
    vs_pulse;
    for (int k = 0; k < 16; k++) begin
      drive_pix(k);
      capture_start = (k == 10);
      tick;
    end
    capture_start = 1'b0;
    idle(2);
    n_cmp++;
    if (busy !== 1'b1 || word_count !== 14'd2) begin
      n_bad++;
      $display("FAIL start_ignored: got busy=%b wc=%0d expected busy=1 wc=2", busy, word_count);
    end
    reset_n = 1'b0;
    tick;
    n_cmp++;
    if ({busy, capture_done, overflow, word_count, line_count, pixels_per_line} !== 41'd0) begin
      n_bad++;
      $display("FAIL midreset_status: got busy=%b done=%b ovf=%b wc=%0d lc=%0d ppl=%0d expected all 0",
               busy, capture_done, overflow, word_count, line_count, pixels_per_line);
    end
    n_cmp++;
    if ({mif.onchip_mem_chip_select, mif.onchip_mem_clken, mif.onchip_mem_write} !== 3'b000
        || mif.onchip_mem_addr !== 13'd0) begin
      n_bad++;
      $display("FAIL midreset_mem_ctrl: got cs/ck/wr=%b%b%b addr=%0d expected 0",
               mif.onchip_mem_chip_select, mif.onchip_mem_clken, mif.onchip_mem_write, mif.onchip_mem_addr);
    end
    n_cmp++;
    if (mif.onchip_mem_write_data !== 256'd0 || mif.onchip_mem_byte_enable !== 32'd0
        || mif_s.onchip_mem_write_data !== 256'd0) begin
      n_bad++;
      $display("FAIL midreset_data_be: got data %h be %h expected 0", mif.onchip_mem_write_data, mif.onchip_mem_byte_enable);
    end
    reset_n = 1'b1;
    idle(2);
    n_cmp++;
    if (busy !== 1'b0 || busy_s !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_after: got busy=%b busy_s=%b expected 0 0", busy, busy_s);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    capture_start = 1'b0;
    capture_abort = 1'b0;
    vid_de        = 1'b0;
    vid_hs        = 1'b1;
    vid_vs        = 1'b0;
    vid_r         = '0;
    vid_g         = '0;
    vid_b         = '0;
    test_reset;
    test_full_frame;
    test_partial_flush;
    test_overflow;
    test_abort;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
